// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for blocks that write the LCD text RAM.
//   lcd_state_e : state encoding of the field write scheduler FSM
//   ASCII_*     : character codes used when rendering hex fields
//   hex2ascii() : one hex nibble -> ASCII '0'..'9' / 'A'..'F'
// ---------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } lcd_state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;

    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_ZERO + {4'd0, nib};
        end
        return ASCII_A + {4'd0, nib} - 8'd10;
    endfunction

endpackage : lcd_pkg

// File: rtl/lcd_rr_arb.sv
// ---------------------------------------------------------------------------
// lcd_rr_arb
// Combinational round-robin arbiter. The search for a set request bit starts
// at last_i+1 and wraps, so the most recently served requester has the
// lowest priority.
//   req_i     [NREQ] : request vector
//   last_i    [IW]   : index of the previously granted requester
//   gnt_o     [NREQ] : one-hot grant (all zero when no request)
//   gnt_idx_o [IW]   : index of the granted requester
//   valid_o          : at least one request is pending
// ---------------------------------------------------------------------------
module lcd_rr_arb #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            valid_o
);

    always_comb begin
        // NOTE: every output gets a default before the search loop so no
        // path through the block leaves a value unassigned (no latches).
        int  idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_i) + k) % NREQ;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = IW'(idx);
            end
        end
        valid_o = found;
    end

endmodule : lcd_rr_arb

// File: rtl/lcd_field_sched.sv
// ---------------------------------------------------------------------------
// lcd_field_sched
// Write scheduler for the LCD text RAM. Status sources each own a hex field
// of DIGITS characters starting at FIELD_BASE[i]. Requests are arbitrated
// round-robin; the granted value is latched, rendered MS nibble first as
// ASCII (optionally blanking leading zeros) and streamed one char per clock.
//   clk, rstn        : clock, asynchronous active-low reset
//   req      [NREQ]  : level request, bit i rewrites field i
//   val [NREQ*4*DIGITS] : slice i is the binary value of field i
//   lz_blank         : write leading zeros as spaces
//   ack      [NREQ]  : one-cycle pulse after field i is fully written
//   busy             : high from the first write until the end of ACK
//   wraddr, wrdata, wren : text RAM write port
// Service period per field is DIGITS+2 cycles (grant, DIGITS writes, ACK).
// ---------------------------------------------------------------------------
module lcd_field_sched
    import lcd_pkg::*;
#(
    parameter int                  NREQ       = 4,
    parameter int                  DIGITS     = 4,
    parameter logic [NREQ*8-1:0]   FIELD_BASE = {8'h18, 8'h10, 8'h08, 8'h00}
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*4*DIGITS-1:0] val,
    input  logic                     lz_blank,
    output logic [NREQ-1:0]          ack,
    output logic                     busy,
    output logic [7:0]               wraddr,
    output logic [7:0]               wrdata,
    output logic                     wren
);

    localparam int VW = 4 * DIGITS;
    localparam int IW = $clog2(NREQ);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DIGITS - 1);

    // Arbiter
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;

    // Control and datapath state
    lcd_state_e      state_q;
    logic [IW-1:0]   last_q;
    logic [NREQ-1:0] gnt_q;
    logic [VW-1:0]   shreg_q;   // latched value, shifted left one nibble per write
    logic            blank_q;   // still inside the run of leading zeros
    logic [7:0]      base_q;
    logic [DW-1:0]   d_q;

    // Registered outputs
    logic [NREQ-1:0] ack_q;
    logic            busy_q;
    logic [7:0]      wraddr_q;
    logic [7:0]      wrdata_q;
    logic            wren_q;

    lcd_rr_arb #(.NREQ(NREQ)) u_arb (
        .req_i    (req),
        .last_i   (last_q),
        .gnt_o    (arb_gnt),
        .gnt_idx_o(arb_idx),
        .valid_o  (arb_valid)
    );

    // Value and base address of the requester being granted this cycle.
    logic [VW-1:0] sel_val;
    logic [7:0]    sel_base;

    always_comb begin
        sel_val  = '0;
        sel_base = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_val  = val[i*VW +: VW];
                sel_base = FIELD_BASE[i*8 +: 8];
            end
        end
    end

    // Character for the current digit. The last digit is never blanked so
    // that a zero value still shows a single '0'.
    logic [3:0] nib;
    logic       digit_last;
    logic       blank_nib;
    logic [7:0] char_d;

    assign nib        = shreg_q[VW-1 -: 4];
    assign digit_last = (d_q == D_LAST);
    assign blank_nib  = blank_q && (nib == 4'd0) && !digit_last;
    assign char_d     = blank_nib ? ASCII_SPACE : hex2ascii(nib);

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            last_q   <= IW'(NREQ - 1);
            gnt_q    <= '0;
            shreg_q  <= '0;
            blank_q  <= 1'b0;
            base_q   <= '0;
            d_q      <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            wraddr_q <= '0;
            wrdata_q <= '0;
            wren_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q  <= '0;
                    busy_q <= 1'b0;
                    wren_q <= 1'b0;
                    if (arb_valid) begin
                        gnt_q   <= arb_gnt;
                        last_q  <= arb_idx;
                        shreg_q <= sel_val;
                        blank_q <= lz_blank;
                        base_q  <= sel_base;
                        d_q     <= '0;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    busy_q   <= 1'b1;
                    wren_q   <= 1'b1;
                    wraddr_q <= base_q + 8'(d_q);   // wraps modulo 256
                    wrdata_q <= char_d;
                    shreg_q  <= shreg_q << 4;
                    blank_q  <= blank_nib;
                    d_q      <= d_q + 1'b1;
                    if (digit_last) begin
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    wren_q  <= 1'b0;
                    ack_q   <= gnt_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack    = ack_q;
    assign busy   = busy_q;
    assign wraddr = wraddr_q;
    assign wrdata = wrdata_q;
    assign wren   = wren_q;

endmodule : lcd_field_sched

// File: tb/tb_lcd_field_sched.sv
// ---------------------------------------------------------------------------
// tb_lcd_field_sched
// Self-checking bench for lcd_field_sched. A transaction-level model turns
// each grant into the expected list of per-cycle outputs (DIGITS writes then
// one ACK cycle) and compares the DUT against it every clock.
// ---------------------------------------------------------------------------
module tb_lcd_field_sched;

    localparam int NREQ   = 4;
    localparam int DIGITS = 4;
    localparam int VW     = 4 * DIGITS;
    localparam logic [NREQ*8-1:0] FB = {8'h18, 8'h10, 8'h08, 8'h00};

    logic                  clk  = 1'b0;
    logic                  rstn = 1'b1;
    logic [NREQ-1:0]       req  = '0;
    logic [NREQ*VW-1:0]    val  = '0;
    logic                  lz_blank = 1'b0;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic [7:0]            wraddr;
    logic [7:0]            wrdata;
    logic                  wren;

    lcd_field_sched #(
        .NREQ      (NREQ),
        .DIGITS    (DIGITS),
        .FIELD_BASE(FB)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .val     (val),
        .lz_blank(lz_blank),
        .ack     (ack),
        .busy    (busy),
        .wraddr  (wraddr),
        .wrdata  (wrdata),
        .wren    (wren)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic            wren;
        logic [7:0]      addr;
        logic [7:0]      data;
        logic [NREQ-1:0] ack;
        logic            busy;
    } exp_t;

    exp_t        pend[$];
    exp_t        cur;
    int          m_last;
    logic [7:0]  m_addr;
    logic [7:0]  m_data;

    // Observation logs and bench controls
    logic [7:0]      cap_addr[$];
    logic [7:0]      cap_data[$];
    int              ack_log[$];
    int              ack_cyc[$];
    logic [NREQ-1:0] drop_mask = '1;
    logic            rand_vals = 1'b0;
    int              cyc = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ASCII for digit k (0 = most significant) of value v.
    function automatic logic [7:0] ref_char(input logic [VW-1:0] v, input int k, input logic lz);
        int unsigned vv;
        int unsigned sh;
        int unsigned n;
        vv = v;
        sh = 4 * (DIGITS - 1 - k);
        n  = (vv >> sh) & 32'hF;
        if (lz && (k < DIGITS - 1) && ((vv >> sh) == 0)) return 8'h20;
        if (n < 10) return 8'(48 + n);
        return 8'(55 + n);
    endfunction

    task automatic model_reset();
        pend.delete();
        m_last = NREQ - 1;
        m_addr = 8'h00;
        m_data = 8'h00;
    endtask

    // Expected outputs after the coming clock edge, given the current inputs.
    task automatic model_edge();
        exp_t e;
        if (pend.size() == 0) begin
            cur.wren = 1'b0;
            cur.addr = m_addr;
            cur.data = m_data;
            cur.ack  = '0;
            cur.busy = 1'b0;
            if (req != '0) begin
                int g;
                logic [7:0]    base;
                logic [VW-1:0] v;
                g = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    int i;
                    i = (m_last + k) % NREQ;
                    if (g < 0 && req[i]) g = i;
                end
                m_last = g;
                base = FB[g*8 +: 8];
                v    = val[g*VW +: VW];
                for (int k = 0; k < DIGITS; k++) begin
                    e.wren = 1'b1;
                    e.addr = 8'(int'(base) + k);
                    e.data = ref_char(v, k, lz_blank);
                    e.ack  = '0;
                    e.busy = 1'b1;
                    pend.push_back(e);
                end
                e.wren = 1'b0;
                e.ack  = NREQ'(1 << g);
                e.busy = 1'b1;
                pend.push_back(e);
            end
        end else begin
            cur = pend.pop_front();
        end
        m_addr = cur.addr;
        m_data = cur.data;
    endtask

    // One clock: predict, clock, compare, then update stimulus.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check("wren",   {31'd0, wren}, {31'd0, cur.wren});
        check("wraddr", {24'd0, wraddr}, {24'd0, cur.addr});
        check("wrdata", {24'd0, wrdata}, {24'd0, cur.data});
        check("ack",    {28'd0, ack}, {28'd0, cur.ack});
        check("busy",   {31'd0, busy}, {31'd0, cur.busy});
        if (wren === 1'b1) begin
            cap_addr.push_back(wraddr);
            cap_data.push_back(wrdata);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i] === 1'b1) begin
                ack_log.push_back(i);
                ack_cyc.push_back(cyc);
            end
            if (cur.ack[i] && drop_mask[i]) req[i] = 1'b0;
        end
        if (rand_vals) begin
            val      = {$urandom, $urandom};
            lz_blank = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        #1;
        check({tag, "_wren"},   {31'd0, wren}, 32'd0);
        check({tag, "_ack"},    {28'd0, ack}, 32'd0);
        check({tag, "_busy"},   {31'd0, busy}, 32'd0);
        check({tag, "_wraddr"}, {24'd0, wraddr}, 32'd0);
        check({tag, "_wrdata"}, {24'd0, wrdata}, 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Compare the last DIGITS captured writes against literal characters.
    task automatic expect_chars(input string tag, input logic [7:0] base, input logic [31:0] chars);
        check({tag, "_count"}, cap_addr.size(), DIGITS);
        if (cap_addr.size() == DIGITS) begin
            for (int k = 0; k < DIGITS; k++) begin
                check({tag, "_addr"}, {24'd0, cap_addr[k]}, {24'd0, 8'(int'(base) + k)});
                check({tag, "_char"}, {24'd0, cap_data[k]}, {24'd0, chars[31-8*k -: 8]});
            end
        end
        cap_addr.delete();
        cap_data.delete();
    endtask

    initial begin
        int n0;
        int found;

        #2;
        do_reset("rst");

        // Single request, no blanking
        val[0*VW +: VW] = 16'h1A3F;
        lz_blank = 1'b0;
        req = 4'b0001;
        run(7);
        expect_chars("single", 8'h00, {8'h31, 8'h41, 8'h33, 8'h46});

        // Leading-zero blanking on field 1
        lz_blank = 1'b1;
        val[1*VW +: VW] = 16'h0007;
        req = 4'b0010;
        run(7);
        expect_chars("blank7", 8'h08, {8'h20, 8'h20, 8'h20, 8'h37});
        val[1*VW +: VW] = 16'h0000;
        req = 4'b0010;
        run(7);
        expect_chars("blank0", 8'h08, {8'h20, 8'h20, 8'h20, 8'h30});
        val[1*VW +: VW] = 16'h0100;
        req = 4'b0010;
        run(7);
        expect_chars("blank100", 8'h08, {8'h20, 8'h31, 8'h30, 8'h30});

        // Simultaneous requests from reset
        do_reset("rst2");
        val = {$urandom, $urandom};
        lz_blank = 1'b0;
        req = 4'b1111;
        ack_log.delete();
        ack_cyc.delete();
        cap_addr.delete();
        cap_data.delete();
        run(4 * (DIGITS + 2) + 2);
        check("simul_acks", ack_log.size(), 4);
        check("simul_writes", cap_addr.size(), 16);
        for (int i = 0; i < ack_log.size(); i++) begin
            check("simul_order", ack_log[i], i);
            if (i > 0) check("simul_spacing", ack_cyc[i] - ack_cyc[i-1], DIGITS + 2);
        end
        cap_addr.delete();
        cap_data.delete();

        // Fairness: req0 and req2 held, req1 raised mid-sequence
        drop_mask = 4'b1010;
        req = 4'b0101;
        ack_log.delete();
        run(4 * (DIGITS + 2));
        for (int i = 0; i < ack_log.size(); i++) begin
            check("fair_alt", ack_log[i], (i % 2 == 0) ? 0 : 2);
        end
        run(2);
        n0 = ack_log.size();
        req[1] = 1'b1;
        run(3 * (DIGITS + 2));
        found = 0;
        for (int i = n0; i < ack_log.size() && i < n0 + 3; i++) begin
            if (ack_log[i] == 1) found = 1;
        end
        check("fair_req1", found, 1);
        drop_mask = '1;
        req = '0;
        run(DIGITS + 3);

        // Randomized requests with val/lz_blank changing every cycle
        rand_vals = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = req | NREQ'($urandom);
            step();
        end
        req = '0;
        run(DIGITS + 3);
        rand_vals = 1'b0;

        // Reset in the middle of a field write
        val = {$urandom, $urandom};
        req = 4'b0100;
        run(3);  // grant, first write, second write
        #2;
        req = 4'b1000;
        do_reset("midrst");
        ack_log.delete();
        run(DIGITS + 3);
        check("midrst_acks", ack_log.size(), 1);
        if (ack_log.size() > 0) check("midrst_req3", ack_log[0], 3);

        do_reset("rst3");
        req = 4'b1111;
        ack_log.delete();
        run(4 * (DIGITS + 2) + 2);
        check("restart_acks", ack_log.size(), 4);
        if (ack_log.size() > 0) check("restart_req0", ack_log[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_lcd_field_sched

// File: doc/lcd_field_sched.md
# lcd_field_sched

Write scheduler for the 32-character LCD text RAM write port (`wraddr`/`wrdata`/`wren`) of the LCD display interface. Up to `NREQ` status sources (format detect, CRC error count, line count, and so on) each own a fixed hex field on the display. The block arbitrates their update requests round-robin, converts the latched binary value to ASCII hex digits with optional leading-zero blanking, and streams one character per clock into the RAM.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DIGITS`, 4: hex digits per field, 1..8.
- `FIELD_BASE`, `{8'h18,8'h10,8'h08,8'h00}`: `NREQ`×8-bit vector; slice i is the first RAM address of field i.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rstn` in 1: asynchronous active-low reset.
- `req` in `NREQ`: level request; bit i asks for a rewrite of field i.
- `val` in `NREQ*4*DIGITS`: slice i is the binary value of field i.
- `lz_blank` in 1: 1 means leading zeros are written as space (0x20).
- `ack` out `NREQ`: one-cycle pulse when field i has been fully written.
- `busy` out 1: high from grant until the end of the ACK cycle.
- `wraddr` out 8: RAM write address.
- `wrdata` out 8: RAM write data (ASCII).
- `wren` out 1: RAM write enable.

## Operation
- FSM states are IDLE, WRITE and ACK. Reset state is IDLE.
- **IDLE**
  - If any `req` bit is set, grant `g` = the first set bit searching cyclically from `last`+1.
  - Latch `val[g]`, `lz_blank` and `FIELD_BASE[g]`, clear the digit counter `d`, set `last` = `g`, then go to WRITE.
  - Otherwise stay in IDLE.
- **WRITE**
  - One character per cycle, most-significant nibble first.
  - `wraddr` = base + `d`, computed modulo 256 (no saturation).
  - Nibble 0–9 maps to 0x30+n. Nibble A–F maps to 0x41+(n−10).
  - With blanking on, a nibble is written as 0x20 while it and all preceding nibbles are zero. The last digit is never blanked, so a value of 0 displays as "0".
  - When `d` = `DIGITS`−1, go to ACK.
- **ACK**
  - `ack[g]` = 1 and `wren` = 0 for one cycle, then IDLE.
- `val` and `lz_blank` changes after the grant are ignored until the next grant.
- If `req[g]` drops during WRITE, the field still completes and `ack` still pulses.
- A requester must drop `req` in its ACK cycle. If it does not, it is re-granted at its round-robin turn; this is legal and causes a repeated write.
- Simultaneous requests are granted one per IDLE visit in round-robin order.
- Fields are not checked for overlap. Overlapping writes land last-writer-wins.

## Timing
- All outputs are registered.
- Reset values: `wren`=0, `wraddr`=0, `wrdata`=0, `ack`=0, `busy`=0, `last`=`NREQ`−1 (so req0 has top priority after reset).
- Grant decision at IDLE edge t produces:
  - `wren` high for cycles t+1 .. t+`DIGITS`;
  - `ack` at t+`DIGITS`+1;
  - the next possible grant at t+`DIGITS`+2.
- Service period per field is `DIGITS`+2 cycles, which is 6 with defaults.
- `busy` rises at t+1 and falls after t+`DIGITS`+1.
- Reset asserted mid-operation: all outputs clear immediately (asynchronously), no `ack` is issued, the field is left partially written, and the FSM restarts in IDLE.

## Structure
- Shared package `lcd_pkg`, used by this block and future LCD writers:
  - FSM state encoding;
  - ASCII constants (0x20 space, 0x30 zero, 0x41 'A');
  - a `hex2ascii` function (4-bit in, 8-bit out).
- One sub-module, `lcd_rr_arb`: parameterised `NREQ` round-robin arbiter. Inputs are `req` and `last`; outputs are a one-hot grant, a grant index and a valid flag. Purely combinational.
- Top level holds the FSM, the latched value shift register, the digit counter and the blanking flag.

## Test plan
- **Single request, no blanking.** req0 with `val[0]`=0x1A3F, `lz_blank`=0, base 0x00 → writes (0x00,0x31), (0x01,0x41), (0x02,0x33), (0x03,0x46) on t+1..t+4; `ack[0]` at t+5; `busy` falls with it.
- **Blanking.** req1 with `val`=0x0007, `lz_blank`=1 → at 0x08..0x0B writes 0x20, 0x20, 0x20, 0x37. With `val`=0x0000 → 0x20, 0x20, 0x20, 0x30. With `val`=0x0100 → 0x20, 0x31, 0x30, 0x30.
- **Simultaneous requests.** `req`=4'b1111 from reset, each dropped on its ACK cycle → grant order 0,1,2,3; `ack` pulses exactly 6 cycles apart; 16 writes with no gaps other than the ACK/IDLE cycles.
- **Fairness.** req0 held high permanently plus req2 held high → grant sequence 0,2,0,2,…; req1 raised mid-sequence is served within two grants.
- **Value changes after grant.** Change `val[0]` and `lz_blank` during WRITE → written characters reflect the values latched at grant.
- **Reset mid-write.** Assert `rstn`=0 after the second write → `wren`/`ack`/`busy` go 0 at once. After release, req3 alone is granted first, and priority order restarts at req0.
